// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions: format constants, command op codes,
// serialiser states and the exponent/mantissa packing helper.
// Build option: DLFMAC_SAT_EN selects saturating exponent handling;
// when undefined the exponent wraps modulo 64.
package dlfloat_pkg;

  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int BIAS  = 31;

  localparam logic [15:0] DLF_NAN  = 16'hFFFF;
  localparam logic [15:0] DLF_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    OP_MAC   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_READ  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    SER_IDLE = 2'b00,
    SER_LO   = 2'b01,
    SER_HI   = 2'b10
  } ser_state_t;

  // Pack sign, a signed 9-bit biased exponent and a 9-bit mantissa into a
  // DLFloat16 word. The exponent arrives as two's complement so both
  // overflow (>62) and underflow (<1) can be detected before packing.
  function automatic logic [15:0] dlf_pack(input logic sgn,
                                           input logic [8:0] exp9,
                                           input logic [MAN_W-1:0] man);
`ifdef DLFMAC_SAT_EN
    if (!exp9[8] && (exp9 > 9'd62))
      return DLF_NAN;
    else if (exp9[8] || (exp9 == 9'd0))
      return DLF_ZERO;
    else
      return {sgn, exp9[EXP_W-1:0], man};
`else
    return {sgn, exp9[EXP_W-1:0], man};
`endif
  endfunction

endpackage

// File: rtl/dlfloat_add_norm.sv
// Combinational DLFloat16 adder: align the smaller operand, add or
// subtract, renormalise, truncate. 0xFFFF is sticky, a zero operand
// passes the other through, exact cancellation yields 0x0000.
// Build option: DLFMAC_SAT_EN (saturation, see dlfloat_pkg::dlf_pack).
module dlfloat_add_norm
  import dlfloat_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic        a_big;
  logic [15:0] big;
  logic [15:0] sml;
  logic [5:0]  ediff;
  logic [12:0] mb;
  logic [12:0] ms;
  logic [13:0] sum;
  logic [12:0] diff;
  logic [12:0] norm;
  logic [3:0]  lz;
  logic [8:0]  exp_r;
  logic [8:0]  man_r;
  logic        cancel;

  // Align / add / normalise with three guard bits, then apply specials.
  always_comb begin
    a_big  = (a[14:0] >= b[14:0]);
    big    = a_big ? a : b;
    sml    = a_big ? b : a;
    ediff  = big[14:9] - sml[14:9];
    mb     = {1'b1, big[8:0], 3'b000};
    ms     = {1'b1, sml[8:0], 3'b000} >> ediff;
    sum    = {1'b0, mb} + {1'b0, ms};
    diff   = mb - ms;
    lz     = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (diff[i]) lz = 4'(12 - i);
    end
    norm   = diff << lz;
    cancel = 1'b0;
    exp_r  = {3'b000, big[14:9]};
    man_r  = '0;
    if (big[15] == sml[15]) begin
      if (sum[13]) begin
        exp_r = {3'b000, big[14:9]} + 9'd1;
        man_r = sum[12:4];
      end else begin
        man_r = sum[11:3];
      end
    end else begin
      cancel = (diff == 13'd0);
      exp_r  = {3'b000, big[14:9]} - {5'b00000, lz};
      man_r  = norm[11:3];
    end

    if ((a == DLF_NAN) || (b == DLF_NAN))
      y = DLF_NAN;
    else if (a == DLF_ZERO)
      y = b;
    else if (b == DLF_ZERO)
      y = a;
    else if (cancel)
      y = DLF_ZERO;
    else
      y = dlf_pack(big[15], exp_r, man_r);
  end

endmodule

// File: rtl/dlfloat_mac_array.sv
// N_CH-channel DLFloat16 multiply-accumulate array. Commands enter a
// two-stage pipeline (S1 operands, S2 product + accumulator update);
// READ results leave over a byte-serial port, low byte first.
// Build option: DLFMAC_SAT_EN (saturating exponents; otherwise wrap).
module dlfloat_mac_array
  import dlfloat_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [CH_W-1:0] in_ch,
  input  logic [15:0]     in_a,
  input  logic [15:0]     in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            out_last,
  output logic            busy
);

  logic            s1_valid;
  op_t             s1_op;
  logic [CH_W-1:0] s1_ch;
  logic [15:0]     s1_a;
  logic [15:0]     s1_b;

  logic            s2_valid;
  op_t             s2_op;
  logic [CH_W-1:0] s2_ch;
  logic [15:0]     s2_prod;

  ser_state_t      ser_state;
  logic [15:0]     ser_word;

  logic [15:0]     acc [N_CH];
  logic [15:0]     acc_rd;
  logic [15:0]     acc_sum;
  logic [15:0]     prod;
  logic [19:0]     mp;
  logic [8:0]      pe;
  logic [8:0]      pm;

  logic            ch_ok;
  logic            s2_is_read;
  logic            ser_free;
  logic            hold;
  logic            ser_load;

  // A READ in S2 may leave when the serialiser is idle or finishing its
  // high byte this cycle; otherwise S2 (and an occupied S1) must wait.
  assign ch_ok      = ({{(32-CH_W){1'b0}}, in_ch} < 32'(N_CH));
  assign s2_is_read = s2_valid && (s2_op == OP_READ);
  assign ser_free   = (ser_state == SER_IDLE) || ((ser_state == SER_HI) && out_ready);
  assign hold       = s2_is_read && !ser_free;
  assign ser_load   = s2_is_read && ser_free;
  assign in_ready   = !(s1_valid && hold);
  assign busy       = s1_valid || s2_valid || (ser_state != SER_IDLE);

  // Multiplier on the S1 operands: truncated mantissa product, exponent
  // ea+eb-BIAS plus one when the product of significands reaches 2.
  always_comb begin
    mp = {1'b1, s1_a[8:0]} * {1'b1, s1_b[8:0]};
    pe = {3'b000, s1_a[14:9]} + {3'b000, s1_b[14:9]} - 9'(BIAS) + {8'd0, mp[19]};
    pm = mp[19] ? mp[18:10] : mp[17:9];
    if ((s1_a == DLF_NAN) || (s1_b == DLF_NAN))
      prod = DLF_NAN;
    else if ((s1_a == DLF_ZERO) || (s1_b == DLF_ZERO))
      prod = DLF_ZERO;
    else
      prod = dlf_pack(s1_a[15] ^ s1_b[15], pe, pm);
  end

  // S1: capture accepted commands; out-of-range channels are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MAC;
      s1_ch    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid && ch_ok;
      s1_op    <= op_t'(in_op);
      s1_ch    <= in_ch;
      s1_a     <= in_a;
      s1_b     <= in_b;
    end
  end

  // S2: capture the product alongside the command unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_op    <= OP_MAC;
      s2_ch    <= '0;
      s2_prod  <= '0;
    end else if (!hold) begin
      s2_valid <= s1_valid;
      s2_op    <= s1_op;
      s2_ch    <= s1_ch;
      s2_prod  <= prod;
    end
  end

  // Read and write of the accumulator both happen in S2, so consecutive
  // MACs to one channel see each other's result without forwarding.
  assign acc_rd = acc[s2_ch];

  dlfloat_add_norm u_add (
    .a (acc_rd),
    .b (s2_prod),
    .y (acc_sum)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_acc
      logic [15:0] acc_reg;
      logic        wr_sel;
      assign wr_sel  = s2_valid && !hold && (s2_ch == CH_W'(gi));
      assign acc[gi] = acc_reg;

      // Per-channel accumulator update for MAC / LOAD / CLEAR.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= DLF_ZERO;
        end else if (wr_sel) begin
          case (s2_op)
            OP_MAC:   acc_reg <= acc_sum;
            OP_LOAD:  acc_reg <= s2_prod;
            OP_CLEAR: acc_reg <= DLF_ZERO;
            default:  acc_reg <= acc_reg;
          endcase
        end
      end
    end
  endgenerate

  // Serialiser FSM with registered byte outputs; a new READ may chain
  // straight out of HI so back-to-back words have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_state <= SER_IDLE;
      ser_word  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (ser_state)
        SER_IDLE: begin
          if (ser_load) begin
            ser_state <= SER_LO;
            ser_word  <= acc_rd;
            out_valid <= 1'b1;
            out_data  <= acc_rd[7:0];
            out_last  <= 1'b0;
          end
        end
        SER_LO: begin
          if (out_ready) begin
            ser_state <= SER_HI;
            out_data  <= ser_word[15:8];
            out_last  <= 1'b1;
          end
        end
        SER_HI: begin
          if (out_ready) begin
            if (ser_load) begin
              ser_state <= SER_LO;
              ser_word  <= acc_rd;
              out_valid <= 1'b1;
              out_data  <= acc_rd[7:0];
              out_last  <= 1'b0;
            end else begin
              ser_state <= SER_IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
            end
          end
        end
        default: begin
          ser_state <= SER_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_array.sv
// Directed bench for dlfloat_mac_array with hand-computed DLFloat16
// results (1.0=0x3E00, 2.0=0x4000, 3.0=0x4100, 6.0=0x4300).
module tb_dlfloat_mac_array;

  localparam logic [1:0] MAC = 2'b00, LOAD = 2'b01, READ = 2'b10, CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [1:0]  in_ch = 2'b00;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dlfloat_mac_array #(.N_CH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_ch(in_ch),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  // Present a command and return one cycle after it is accepted.
  task automatic cmd(input logic [1:0] op, input logic [1:0] ch,
                     input logic [15:0] a, input logic [15:0] b, output int stalls);
    stalls = 0;
    in_valid = 1'b1; in_op = op; in_ch = ch; in_a = a; in_b = b;
    #1;
    while (!in_ready && stalls < 200) begin
      @(posedge clk); #1; stalls++;
    end
    if (stalls >= 200) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Take one byte off the output port.
  task automatic get_byte(output logic [7:0] d, output logic last);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("byte_timeout", 32'd0, 32'd1);
    d = out_data; last = out_last;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [1:0] ch, input logic [15:0] exp);
    int s;
    logic [7:0] lo, hi;
    logic ll, hl;
    cmd(READ, ch, 16'h0, 16'h0, s);
    idle();
    get_byte(lo, ll);
    get_byte(hi, hl);
    chk({tag, "_word"}, {16'h0, hi, lo}, {16'h0, exp});
    chk({tag, "_lasts"}, {30'h0, ll, hl}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [7:0] d;
    logic l;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_last", {31'h0, out_last}, 32'h0);
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // 1.0*2.0 into a cleared channel: bytes 0x00 then 0x40
    cmd(CLR, 2'd0, 16'h0, 16'h0, s);
    cmd(MAC, 2'd0, 16'h3E00, 16'h4000, s);
    cmd(READ, 2'd0, 16'h0, 16'h0, s);
    idle();
    get_byte(d, l);
    chk("ch0_lo_byte", {24'h0, d}, 32'h00);
    chk("ch0_lo_last", {31'h0, l}, 32'h0);
    get_byte(d, l);
    chk("ch0_hi_byte", {24'h0, d}, 32'h40);
    chk("ch0_hi_last", {31'h0, l}, 32'h1);

    // LOAD 3.0 then back-to-back MAC 3.0 -> 6.0, no stall on the MAC
    cmd(LOAD, 2'd1, 16'h3F00, 16'h4000, s);
    cmd(MAC, 2'd1, 16'h3F00, 16'h4000, s);
    chk("ch1_mac_stalls", s, 32'd0);
    idle();
    read_word("ch1_six", 2'd1, 16'h4300);

    // Exact cancellation, NaN stickiness, CLEAR
    cmd(MAC, 2'd2, 16'h3E00, 16'h4000, s);
    cmd(MAC, 2'd2, 16'hBE00, 16'h4000, s);
    idle();
    read_word("ch2_cancel", 2'd2, 16'h0000);
    cmd(MAC, 2'd2, 16'hFFFF, 16'h3E00, s);
    cmd(MAC, 2'd2, 16'h3E00, 16'h3E00, s);
    idle();
    read_word("ch2_nan_sticky", 2'd2, 16'hFFFF);
    cmd(CLR, 2'd2, 16'h0, 16'h0, s);
    idle();
    read_word("ch2_cleared", 2'd2, 16'h0000);
    cmd(LOAD, 2'd3, 16'hFFFF, 16'h0000, s);
    idle();
    read_word("ch3_nan_over_zero", 2'd3, 16'hFFFF);

    // Back-pressure: READ ch0, ch1, ch2 with out_ready low
    cmd(READ, 2'd0, 16'h0, 16'h0, s);
    cmd(READ, 2'd1, 16'h0, 16'h0, s);
    cmd(READ, 2'd2, 16'h0, 16'h0, s);
    idle();
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_hold_byte", {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'h00});
      @(posedge clk); #1;
    end
    chk("bp_busy", {31'h0, busy}, 32'h1);
    get_byte(d, l); chk("bp_w0_lo", {23'h0, l, d}, {23'h0, 1'b0, 8'h00});
    get_byte(d, l); chk("bp_w0_hi", {23'h0, l, d}, {23'h0, 1'b1, 8'h40});
    get_byte(d, l); chk("bp_w1_lo", {23'h0, l, d}, {23'h0, 1'b0, 8'h00});
    get_byte(d, l); chk("bp_w1_hi", {23'h0, l, d}, {23'h0, 1'b1, 8'h43});
    get_byte(d, l); chk("bp_w2_lo", {23'h0, l, d}, {23'h0, 1'b0, 8'h00});
    get_byte(d, l); chk("bp_w2_hi", {23'h0, l, d}, {23'h0, 1'b1, 8'h00});
    @(posedge clk); #1;
    chk("bp_drained_busy", {31'h0, busy}, 32'h0);

    // Reset after the low byte has gone
    cmd(LOAD, 2'd3, 16'h3E00, 16'h4000, s);
    cmd(READ, 2'd3, 16'h0, 16'h0, s);
    idle();
    get_byte(d, l);
    chk("rstmid_lo_byte", {24'h0, d}, 32'h00);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_word("rst_ch0", 2'd0, 16'h0000);
    read_word("rst_ch1", 2'd1, 16'h0000);
    read_word("rst_ch2", 2'd2, 16'h0000);
    read_word("rst_ch3", 2'd3, 16'h0000);

    // Exponent overflow in the multiplier
    cmd(LOAD, 2'd0, 16'h7C00, 16'h7C00, s);
    idle();
`ifdef DLFMAC_SAT_EN
    read_word("ovf_mul", 2'd0, 16'hFFFF);
`else
    read_word("ovf_mul", 2'd0, 16'h3A00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
